// File: rtl/mul_div_unit_pkg.sv
// ============================================================
// mul_div_unit_pkg: shared encodings and defaults for the MDU.
// Rev 1.0
// ============================================================
`default_nettype none

package mul_div_unit_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITER  = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_signfix.sv
// ============================================================
// mdu_signfix: conditional two's-complement negate (abs / sign fix-up).
// Rev 1.0
// ============================================================
`default_nettype none

module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================
// mul_div_unit: iterative radix-2 MIPS multiply/divide with HI/LO.
// Rev 1.0
// ============================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = DEF_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rdata_A,
  input  logic [WIDTH-1:0] rdata_B,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(ITER + 1);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         op_q;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               last_iter;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     trial;
  logic               can_sub;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign neg_a = op_is_signed(op) & rdata_A[WIDTH-1];
  assign neg_b = op_is_signed(op) & rdata_B[WIDTH-1];

  mdu_signfix #(.W(WIDTH)) u_abs_a (.din(rdata_A), .neg(neg_a), .dout(abs_a));
  mdu_signfix #(.W(WIDTH)) u_abs_b (.din(rdata_B), .neg(neg_b), .dout(abs_b));

  // sa/sb are latched already gated by the signed-op bit
  mdu_signfix #(.W(2*WIDTH)) u_fix_prod (.din(acc), .neg(sa ^ sb), .dout(prod_fix));
  mdu_signfix #(.W(WIDTH)) u_fix_quo (.din(acc[WIDTH-1:0]), .neg(sa ^ sb), .dout(quo_fix));
  mdu_signfix #(.W(WIDTH)) u_fix_rem (.din(acc[2*WIDTH-1:WIDTH]), .neg(sa), .dout(rem_fix));

  assign busy      = (state != S_IDLE);
  assign last_iter = (cnt == CNT_W'(ITER - 1));

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
  assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign can_sub  = (trial >= {1'b0, opnd});
  assign diff     = trial[WIDTH-1:0] - opnd;
  assign rem_next = can_sub ? diff : trial[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= 2'b00;
      sa   <= 1'b0;
      sb   <= 1'b0;
      opnd <= '0;
      acc  <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start) begin
            op_q <= op;
            sa   <= neg_a;
            sb   <= neg_b;
            cnt  <= '0;
            if (op_is_div(op)) begin
              opnd <= abs_b;
              acc  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              opnd <= abs_a;
              acc  <= {{WIDTH{1'b0}}, abs_b};
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_is_div(op_q)) acc <= {rem_next, acc[WIDTH-2:0], can_sub};
          else                 acc <= {msum, acc[WIDTH-1:1]};
        end
        S_FIX: begin
          done <= 1'b1;
          if (op_is_div(op_q)) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================
// tb_mul_div_unit: vector, random and corner-sequence checks of mul_div_unit.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rdata_A = '0;
  logic [31:0] rdata_B = '0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rdata_A(rdata_A), .rdata_B(rdata_B),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: MIPS semantics in plain 64-bit arithmetic, {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa_, sb_, p, q, r;
    sa_ = $signed(a);
    sb_ = $signed(b);
    case (o)
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_MULT: begin
        p = sa_ * sb_;
        return p;
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {a, (sa_ < 0) ? 32'h00000001 : 32'hFFFFFFFF};
        q = sa_ / sb_;
        r = sa_ % sb_;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Waits (bounded) for done; counts edges after the start edge and busy cycles seen.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = busy ? 1 : 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) nb++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int n, nb;
    @(negedge clk);
    op = o; rdata_A = a; rdata_B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rdata_A = $urandom;
    rdata_B = $urandom;
    wait_done(n, nb);
    check({nm, " latency"}, 64'(n), 64'd33);
    check({nm, " busy_cycles"}, 64'(nb), 64'd33);
    check({nm, " hi"}, 64'(hi), 64'(ehi));
    check({nm, " lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
    check({nm, " done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n, nb, ndone;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg"};
    vecs[2] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"};
    vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
    vecs[4] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu_by0"};
    vecs[5] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'h00000001, "div_m5_by0"};
    vecs[6] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};

    // reset state while rst held low
    #12;
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 15) == 0) ra = 32'h80000000;
      exp = ref_model(ro, ra, rb);
      run_op(ro, ra, rb, exp[63:32], exp[31:0], $sformatf("rand%0d op%0d", i, ro));
    end

    // operand changes, start and wr_hi while busy are all ignored
    @(negedge clk);
    op = OP_MULTU; rdata_A = 32'd3; rdata_B = 32'd4; start = 1'b1;
    ndone = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      start   = (c == 5 || c == 20);
      wr_hi   = (c == 10);
      wr_data = $urandom;
      rdata_A = $urandom;
      rdata_B = $urandom;
      op      = 2'($urandom_range(0, 3));
      if (c >= 30) begin
        start = 1'b0;
        wr_hi = 1'b0;
      end
    end
    check("busyign done_count", 64'(ndone), 64'd1);
    check("busyign busy", 64'(busy), 64'd0);
    check("busyign hi", 64'(hi), 64'd0);
    check("busyign lo", 64'(lo), 64'd12);

    // MTHI in idle, then MTLO coinciding with start
    wr_hi = 1'b1; wr_data = 32'hA5A5A5A5;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi hi", 64'(hi), 64'hA5A5A5A5);
    check("mthi lo", 64'(lo), 64'd12);
    op = OP_MULTU; rdata_A = 32'd2; rdata_B = 32'd2; start = 1'b1;
    wr_lo = 1'b1; wr_data = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    check("mtlo lo", 64'(lo), 64'h5A5A5A5A);
    check("mtlo hi", 64'(hi), 64'hA5A5A5A5);
    check("mtlo busy", 64'(busy), 64'd1);
    wait_done(n, nb);
    check("mtlo latency", 64'(n), 64'd33);
    check("mtlo res hi", 64'(hi), 64'd0);
    check("mtlo res lo", 64'(lo), 64'd4);

    // asynchronous reset mid-divide
    @(negedge clk);
    op = OP_DIV; rdata_A = 32'hFFFFFF9C; rdata_B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 9; c++) @(negedge clk);
    check("abort pre busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    check("abort no_activity", 64'(ndone), 64'd0);
    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
